mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum number of WAIT cycles without mem_ack_i before a bus error is flagged (legal range 1..255).
REQ-002 One clock; reset is asynchronous and active-high; the ports SHALL be named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 aluop_i  in  8  operation from EX/MEM latch: EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, or any non-memory op.
REQ-006 mem_addr_i  in  32  effective byte address; reg2_i  in  32  store data.
REQ-007 wd_i  in  5, wreg_i  in  1, wdata_i  in  32  destination register, write enable and EX result.
REQ-008 hi_i, lo_i  in  32 each, whilo_i  in  1  HI/LO write from EX.
REQ-009 mem_ce_o  out  1, mem_we_o  out  1, mem_sel_o  out  4, mem_addr_o  out  32, mem_data_o  out  32  data-bus request.
REQ-010 mem_data_i  in  32, mem_ack_i  in  1  data-bus response.
REQ-011 wd_o  out  5, wreg_o  out  1, wdata_o  out  32, hi_o/lo_o  out  32, whilo_o  out  1  results to MEM/WB.
REQ-012 stop  out  1  pipeline stall request; align_err_o  out  1, bus_err_o  out  1  exception flags.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, DONE.
REQ-014 Non-memory op in IDLE: wd/wreg/wdata/hi/lo/whilo pass through combinationally; stop=0; mem_ce_o=0.
REQ-015 Aligned memory op in IDLE: mem_ce_o=1 and stop=1 in the same cycle; next state WAIT; timeout counter cleared to 0.
REQ-016 Alignment: halfword ops require addr[0]=0, word ops addr[1:0]=00; byte ops always aligned.
REQ-017 Misaligned op: no bus request, align_err_o=1, wreg_o=0, stop=0, remain IDLE.
REQ-018 In WAIT: mem_ce_o=1, stop=1, request signals held stable; counter increments each cycle without ack.
REQ-019 mem_ack_i=1 in IDLE-issue or WAIT cycle: capture mem_data_i into a 32-bit register, next state DONE.
REQ-020 Counter reaching ACK_TIMEOUT without ack: next state DONE with bus_err latched to 1.
REQ-021 In DONE: mem_ce_o=0, stop=0, results valid; next state IDLE unconditionally.
REQ-022 Minimum latency: ack in issue cycle N gives results in cycle N+1; a memory op therefore stalls at least 1 cycle.
REQ-023 Big-endian byte select: addr[1:0]=00->sel 1000 (bits 31:24), 01->0100, 10->0010, 11->0001; halfword 00->1100, 10->0011; word->1111.
REQ-024 mem_addr_o SHALL equal mem_addr_i with bits [1:0] forced to 00.
REQ-025 Stores: mem_we_o=1; mem_data_o replicates reg2_i[7:0] x4 (SB), reg2_i[15:0] x2 (SH), reg2_i (SW); wreg_o=wreg_i, wdata_o=wdata_i.
REQ-026 Loads: mem_we_o=0; selected byte/halfword right-aligned; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits; wdata_o=that value in DONE.
REQ-027 Bus error in DONE: bus_err_o=1, wreg_o=0, whilo_o=0.
REQ-028 hi_o/lo_o/whilo_o pass through unchanged for all non-error cases.
REQ-029 Ack arriving in IDLE with no request or in DONE SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, counter 0, capture register 0, and all outputs to 0 (mem_ce_o, stop, wreg_o, flags, buses) regardless of clk.
REQ-031 Reset asserted in WAIT SHALL abort the access; no DONE cycle follows deassertion.

Verification
REQ-032 LW addr 0x100, ack on 3rd WAIT cycle, data 0x12345678 -> stop=1 for 4 cycles, then wdata_o=0x12345678, wreg_o=1, stop=0.
REQ-033 LB addr 0x103, data 0x000000F0 -> sel 0001, wdata_o=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-034 SH addr 0x202, reg2_i=0xAAAABEEF -> mem_we_o=1, sel 0011, mem_data_o=0xBEEFBEEF, mem_addr_o=0x200.
REQ-035 LW addr 0x101 -> align_err_o=1, mem_ce_o=0, stop=0, wreg_o=0, same cycle.
REQ-036 LW with no ack, ACK_TIMEOUT=4 -> 4 WAIT cycles, DONE with bus_err_o=1, wreg_o=0.
REQ-037 rst pulse during WAIT -> mem_ce_o and stop drop to 0 asynchronously; next op starts cleanly from IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// Pipeline MEM-stage load/store unit: issues a single data-bus access per
// memory op, stalls the pipeline until ack or timeout, then presents results.
//
// state | meaning
// IDLE  | pass-through of non-memory ops; issues aligned memory requests
// WAIT  | request held on the bus, counting cycles without ack
// DONE  | load/store result (or bus error) presented to MEM/WB for one cycle
module mem_lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stop,
  output logic        align_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] CNT_TC     = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q, op_q;
  logic [31:0] cap_q, addr_q, st_q, wdata_q, hi_q, lo_q;
  logic [4:0]  wd_q;
  logic        wreg_q, whilo_q, bus_err_q;

  logic [7:0]  op_c;
  logic [31:0] addr_c, st_c;
  logic        is_ld, is_st, is_mem, sext, misalign, issue;
  logic [1:0]  sz;
  logic [3:0]  sel_c;
  logic [31:0] sdata_c, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Once issued, the request and the load decode come from the captured copy.
  assign op_c   = (state_q == IDLE) ? aluop_i    : op_q;
  assign addr_c = (state_q == IDLE) ? mem_addr_i : addr_q;
  assign st_c   = (state_q == IDLE) ? reg2_i     : st_q;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    sz    = 2'd0;
    case (op_c)
      EXE_LB_OP:  begin is_ld = 1'b1; sext = 1'b1; sz = 2'd0; end
      EXE_LBU_OP: begin is_ld = 1'b1; sz = 2'd0; end
      EXE_LH_OP:  begin is_ld = 1'b1; sext = 1'b1; sz = 2'd1; end
      EXE_LHU_OP: begin is_ld = 1'b1; sz = 2'd1; end
      EXE_LW_OP:  begin is_ld = 1'b1; sz = 2'd2; end
      EXE_SB_OP:  begin is_st = 1'b1; sz = 2'd0; end
      EXE_SH_OP:  begin is_st = 1'b1; sz = 2'd1; end
      EXE_SW_OP:  begin is_st = 1'b1; sz = 2'd2; end
      default: ;
    endcase
  end

  assign is_mem   = is_ld | is_st;
  assign misalign = ((sz == 2'd1) && addr_c[0]) || ((sz == 2'd2) && (addr_c[1:0] != 2'b00));
  assign issue    = (state_q == IDLE) && is_mem && !misalign;

  always_comb begin
    sel_c   = 4'b1111;
    sdata_c = st_c;
    ld_byte = cap_q[31:24];
    ld_half = addr_c[1] ? cap_q[15:0] : cap_q[31:16];
    case (addr_c[1:0])
      2'b00:   ld_byte = cap_q[31:24];
      2'b01:   ld_byte = cap_q[23:16];
      2'b10:   ld_byte = cap_q[15:8];
      default: ld_byte = cap_q[7:0];
    endcase
    case (sz)
      2'd0: begin
        sel_c   = 4'b1000 >> addr_c[1:0];
        sdata_c = {4{st_c[7:0]}};
        ld_val  = sext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      end
      2'd1: begin
        sel_c   = addr_c[1] ? 4'b0011 : 4'b1100;
        sdata_c = {2{st_c[15:0]}};
        ld_val  = sext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      end
      default: ld_val = cap_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      st_q      <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      wdata_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      whilo_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            op_q      <= aluop_i;
            addr_q    <= mem_addr_i;
            st_q      <= reg2_i;
            wd_q      <= wd_i;
            wreg_q    <= wreg_i;
            wdata_q   <= wdata_i;
            hi_q      <= hi_i;
            lo_q      <= lo_i;
            whilo_q   <= whilo_i;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            if (mem_ack_i) begin
              cap_q   <= mem_data_i;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack_i) begin
            cap_q   <= mem_data_i;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == CNT_TC) begin
              bus_err_q <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so they clear immediately, independent of clk.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_sel_o   = 4'b0000;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    hi_o        = '0;
    lo_o        = '0;
    whilo_o     = 1'b0;
    stop        = 1'b0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = is_st;
            mem_sel_o  = sel_c;
            mem_addr_o = {addr_c[31:2], 2'b00};
            mem_data_o = sdata_c;
            stop       = 1'b1;
          end else begin
            wd_o        = wd_i;
            wreg_o      = wreg_i & !is_mem;
            wdata_o     = wdata_i;
            hi_o        = hi_i;
            lo_o        = lo_i;
            whilo_o     = whilo_i;
            align_err_o = is_mem;
          end
        end
        WAIT: begin
          mem_ce_o   = 1'b1;
          mem_we_o   = is_st;
          mem_sel_o  = sel_c;
          mem_addr_o = {addr_c[31:2], 2'b00};
          mem_data_o = sdata_c;
          stop       = 1'b1;
        end
        DONE: begin
          wd_o      = wd_q;
          wreg_o    = wreg_q & !bus_err_q;
          wdata_o   = is_ld ? ld_val : wdata_q;
          hi_o      = hi_q;
          lo_o      = lo_q;
          whilo_o   = whilo_q & !bus_err_q;
          bus_err_o = bus_err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized checks of mem_lsu against a transaction-level
// model of the load/store rules (sizes, big-endian lanes, ack/timeout timing).
module tb_mem_lsu;
  localparam int TO = 4;
  localparam logic [7:0] LB  = 8'hE0, LH  = 8'hE1, LW  = 8'hE3, LBU = 8'hE4;
  localparam logic [7:0] LHU = 8'hE5, SB  = 8'hE8, SH  = 8'hE9, SW  = 8'hEB;

  logic        clk = 1'b0, rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i, mem_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i, mem_ack_i;
  logic        mem_ce_o, mem_we_o, wreg_o, whilo_o, stop, align_err_o, bus_err_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o, mem_data_o, wdata_o, hi_o, lo_o;
  logic [4:0]  wd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
    .whilo_i(whilo_i), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stop(stop),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Byte 0 of a word is its most significant byte (big-endian).
  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int off = int'(addr % 4);
    logic [31:0] v;
    case (op_size(op))
      1: begin
        v = (rdata >> (8 * (3 - off))) & 32'hFF;
        if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = (rdata >> ((off == 0) ? 16 : 0)) & 32'hFFFF;
        if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
    int off = int'(addr % 4);
    case (op_size(op))
      1:       return 4'(1 << (3 - off));
      2:       return (off == 0) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_sdata(input logic [7:0] op, input logic [31:0] d);
    case (op_size(op))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic nonmem_op();
    aluop_i    = 8'($urandom_range(0, 8'hDF));
    mem_addr_i = $urandom;
    reg2_i     = $urandom;
    wd_i       = 5'($urandom);
    wreg_i     = 1'($urandom);
    wdata_i    = $urandom;
    hi_i       = $urandom;
    lo_i       = $urandom;
    whilo_i    = 1'($urandom);
    mem_ack_i  = 1'($urandom);
    mem_data_i = $urandom;
    @(negedge clk);
    chk("pass_wd", 32'(wd_o), 32'(wd_i));
    chk("pass_wreg", 32'(wreg_o), 32'(wreg_i));
    chk("pass_wdata", wdata_o, wdata_i);
    chk("pass_hi", hi_o, hi_i);
    chk("pass_lo", lo_o, lo_i);
    chk("pass_whilo", 32'(whilo_o), 32'(whilo_i));
    chk("pass_stop", 32'(stop), 32'd0);
    chk("pass_ce", 32'(mem_ce_o), 32'd0);
    chk("pass_errs", {30'd0, align_err_o, bus_err_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  // ack_delay: 0 = ack in issue cycle, k = ack in k-th WAIT cycle, > TO = never.
  task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] reg2, input int ack_delay, input logic [31:0] rdata);
    int  sz = op_size(op);
    bit  acked = 0;
    bit  berr;
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = reg2;
    wd_i       = 5'($urandom);
    wreg_i     = ($urandom_range(0, 3) != 0);
    wdata_i    = $urandom;
    hi_i       = $urandom;
    lo_i       = $urandom;
    whilo_i    = 1'($urandom);
    if ((addr % sz) != 0) begin
      mem_ack_i = 1'b0;
      @(negedge clk);
      chk({tag, "_align_err"}, 32'(align_err_o), 32'd1);
      chk({tag, "_align_ce"}, 32'(mem_ce_o), 32'd0);
      chk({tag, "_align_stop"}, 32'(stop), 32'd0);
      chk({tag, "_align_wreg"}, 32'(wreg_o), 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int c = 0; c <= TO; c++) begin
      mem_ack_i  = (c == ack_delay);
      mem_data_i = mem_ack_i ? rdata : $urandom;
      @(negedge clk);
      chk({tag, "_stop"}, 32'(stop), 32'd1);
      chk({tag, "_ce"}, 32'(mem_ce_o), 32'd1);
      chk({tag, "_we"}, 32'(mem_we_o), 32'(op_store(op)));
      chk({tag, "_sel"}, 32'(mem_sel_o), 32'(exp_sel(op, addr)));
      chk({tag, "_addr"}, mem_addr_o, addr - (addr % 4));
      if (op_store(op)) chk({tag, "_sdata"}, mem_data_o, exp_sdata(op, reg2));
      @(posedge clk); #1;
      if (c == ack_delay) begin
        acked = 1;
        break;
      end
    end
    berr       = !acked;
    mem_ack_i  = 1'($urandom);
    mem_data_i = $urandom;
    @(negedge clk);
    chk({tag, "_done_stop"}, 32'(stop), 32'd0);
    chk({tag, "_done_ce"}, 32'(mem_ce_o), 32'd0);
    chk({tag, "_done_buserr"}, 32'(bus_err_o), 32'(berr));
    chk({tag, "_done_wreg"}, 32'(wreg_o), berr ? 32'd0 : 32'(wreg_i));
    chk({tag, "_done_whilo"}, 32'(whilo_o), berr ? 32'd0 : 32'(whilo_i));
    if (!berr) begin
      chk({tag, "_done_wdata"}, wdata_o, op_store(op) ? wdata_i : load_val(op, addr, rdata));
      chk({tag, "_done_wd"}, 32'(wd_o), 32'(wd_i));
      chk({tag, "_done_hilo"}, hi_o ^ lo_o, hi_i ^ lo_i);
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
  endtask

  initial begin
    logic [7:0] ops [8];
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    rst = 1'b1;
    aluop_i = 8'h21; mem_addr_i = 32'h104; reg2_i = 32'h5; wd_i = 5'd7; wreg_i = 1'b1;
    wdata_i = 32'hDEAD_BEEF; hi_i = 32'h1; lo_i = 32'h2; whilo_i = 1'b1;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #3;
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_stop_ce", {30'd0, stop, mem_ce_o}, 32'd0);
    chk("rst_whilo", 32'(whilo_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (4) nonmem_op();

    do_op("lw_ack3", LW, 32'h100, 32'h0, 3, 32'h1234_5678);
    do_op("lb_103", LB, 32'h103, 32'h0, 1, 32'h0000_00F0);
    do_op("lbu_103", LBU, 32'h103, 32'h0, 1, 32'h0000_00F0);
    do_op("sh_202", SH, 32'h202, 32'hAAAA_BEEF, 0, 32'h0);
    do_op("lw_101", LW, 32'h101, 32'h0, 0, 32'h0);
    do_op("lh_odd", LH, 32'h203, 32'h0, 0, 32'h0);
    do_op("lw_timeout", LW, 32'h400, 32'h0, TO + 1, 32'h0);
    do_op("lhu_ack4", LHU, 32'h502, 32'h0, TO, 32'h1234_F00D);
    nonmem_op();

    // Asynchronous reset in the middle of a WAIT cycle aborts the access.
    aluop_i = LW; mem_addr_i = 32'h300; wreg_i = 1'b1; mem_ack_i = 1'b0;
    @(negedge clk);
    chk("abort_issue_ce", 32'(mem_ce_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_wait_stop", 32'(stop), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_async_ce", 32'(mem_ce_o), 32'd0);
    chk("abort_async_stop", 32'(stop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nonmem_op();
    do_op("after_abort", SW, 32'h308, 32'hCAFE_F00D, 2, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) nonmem_op();
      do_op("rand", op, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
    end
    nonmem_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
